sck_rate_detect: RTL

//  Receive-side counterpart of the frontend clock divider. Samples an external serial/bit clock
//  (sck_in) in the clk_in domain and measures its period in clk_in cycles. Declares lock after a
//  run of consistent periods and flags loss of clock. Feeds the I2S receive path and rate logic.

---
 rtl/sck_det_pkg.sv | 24 ++
 rtl/sck_sync_edge.sv | 58 +++++
 rtl/sck_rate_detect.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sck_det_pkg.sv
// sck_det_pkg: shared definitions for the sck rate detector.
//   - sck_state_t : detector state encoding (IDLE is the all-zero reset value)
//   - DEF_*       : default parameter values for sck_rate_detect
//   - match_w()   : width of the consecutive-match counter for a given LOCK_CNT
package sck_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_ACQUIRE = 2'd2,
    ST_LOCKED  = 2'd3
  } sck_state_t;

  localparam int DEF_CNT_W    = 8;
  localparam int DEF_LOCK_CNT = 4;
  localparam int DEF_TOL      = 1;
  localparam int DEF_TIMEOUT  = 200;

  // Bits needed to count 0..lock_cnt consecutive in-tolerance periods.
  function automatic int match_w(input int lock_cnt);
    return $clog2(lock_cnt + 1);
  endfunction

endpackage

// File: rtl/sck_sync_edge.sv
// sck_sync_edge: brings the asynchronous sck into the clk domain and emits a
// registered one-cycle pulse per rising edge.
//   clk_i  : system clock
//   rst_i  : asynchronous active-high reset
//   sck_i  : external serial clock, asynchronous to clk_i
//   rise_o : one-cycle pulse, 3 clk cycles after the sck rise (4 with the filter)
// Optional feature macro: SCK_DET_GLITCH_FILTER_EN inserts a 3-tap majority
// filter after the synchroniser, rejecting single-cycle pulses (+1 cycle latency).
module sck_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sck_i,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q, rise_q;
  logic filt_s, edge_s;

`ifdef SCK_DET_GLITCH_FILTER_EN
  logic h1_q, h2_q;

  // History of the synchronised level for the majority vote.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h1_q <= 1'b0;
      h2_q <= 1'b0;
    end else begin
      h1_q <= s2_q;
      h2_q <= h1_q;
    end
  end

  // Two of the last three samples must agree, so a lone 1-cycle pulse never passes.
  assign filt_s = (s2_q & h1_q) | (s2_q & h2_q) | (h1_q & h2_q);
`else
  assign filt_s = s2_q;
`endif

  assign edge_s = filt_s & ~s3_q;

  // Two-flop synchroniser, delayed copy for edge detection, registered pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= sck_i;
      s2_q   <= s1_q;
      s3_q   <= filt_s;
      rise_q <= edge_s;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/sck_rate_detect.sv
// sck_rate_detect: measures the period of an external sck in clk_in cycles,
// declares lock after LOCK_CNT consecutive consistent periods and flags loss
// of clock after TIMEOUT cycles without an edge.
//   clk_in   : system clock
//   reset    : asynchronous active-high reset
//   sck_in   : external clock, asynchronous to clk_in
//   sck_rise : one-cycle pulse per detected sck rising edge
//   period   : last locked period in clk_in cycles
//   locked   : period is valid and stable
//   lock_err : one-cycle pulse on an out-of-tolerance period while locked
//   lost     : one-cycle pulse on timeout in a non-idle state
// Optional feature macro: SCK_DET_GLITCH_FILTER_EN (see sck_sync_edge).
module sck_rate_detect
  import sck_det_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int TOL      = DEF_TOL,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             sck_in,
  output logic             sck_rise,
  output logic [CNT_W-1:0] period,
  output logic             locked,
  output logic             lock_err,
  output logic             lost
);

  localparam int MATCH_W = match_w(LOCK_CNT);
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]     TOL_V      = (CNT_W+1)'(TOL);
  localparam logic [MATCH_W-1:0] LOCK_V     = MATCH_W'(LOCK_CNT);

  sck_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   ref_q, ref_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               locked_q, locked_d;
  logic               lock_err_q, lock_err_d;
  logic               lost_q, lost_d;

  logic                    rise_s;
  logic                    timeout_s;
  logic                    in_tol_s;
  logic signed [CNT_W:0]   diff_s;
  logic        [CNT_W:0]   mag_s;
  logic [MATCH_W-1:0]      match_inc_s;

  sck_sync_edge u_sync (
    .clk_i  (clk_in),
    .rst_i  (reset),
    .sck_i  (sck_in),
    .rise_o (rise_s)
  );

  // Next-state logic: period counter, tolerance compare and detector FSM.
  always_comb begin
    cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    state_d    = state_q;
    ref_d      = ref_q;
    match_d    = match_q;
    period_d   = period_q;
    locked_d   = locked_q;
    lock_err_d = 1'b0;
    lost_d     = 1'b0;

    // One extra bit keeps the difference exact in both directions.
    diff_s      = $signed({1'b0, cnt_q}) - $signed({1'b0, ref_q});
    mag_s       = diff_s[CNT_W] ? $unsigned(-diff_s) : $unsigned(diff_s);
    // A saturated count means the true period is unknown, so it can never match.
    in_tol_s    = (cnt_q != CNT_MAX) && (mag_s <= TOL_V);
    match_inc_s = match_q + MATCH_W'(1);
    // cnt_q holds TIMEOUT-1 here, so the counter reaches TIMEOUT on this edge
    // and lost rises exactly TIMEOUT cycles after the last sck_rise.
    timeout_s   = (state_q != ST_IDLE) && !rise_s && (cnt_q == TIMEOUT_M1);

    if (rise_s) begin
      cnt_d = CNT_W'(1);
      case (state_q)
        ST_IDLE: begin
          state_d = ST_MEASURE;
        end
        ST_MEASURE: begin
          state_d = ST_ACQUIRE;
          ref_d   = cnt_q;
          match_d = {MATCH_W{1'b0}};
        end
        ST_ACQUIRE: begin
          if (in_tol_s) begin
            match_d = match_inc_s;
            if (match_inc_s == LOCK_V) begin
              state_d  = ST_LOCKED;
              period_d = ref_q;
              locked_d = 1'b1;
            end else begin
              state_d = ST_ACQUIRE;
            end
          end else begin
            ref_d   = cnt_q;
            match_d = {MATCH_W{1'b0}};
          end
        end
        ST_LOCKED: begin
          if (in_tol_s) begin
            state_d = ST_LOCKED;
          end else begin
            state_d    = ST_ACQUIRE;
            ref_d      = cnt_q;
            match_d    = {MATCH_W{1'b0}};
            locked_d   = 1'b0;
            lock_err_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (timeout_s) begin
      state_d  = ST_IDLE;
      locked_d = 1'b0;
      lost_d   = 1'b1;
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      ref_q      <= {CNT_W{1'b0}};
      match_q    <= {MATCH_W{1'b0}};
      period_q   <= {CNT_W{1'b0}};
      locked_q   <= 1'b0;
      lock_err_q <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ref_q      <= ref_d;
      match_q    <= match_d;
      period_q   <= period_d;
      locked_q   <= locked_d;
      lock_err_q <= lock_err_d;
      lost_q     <= lost_d;
    end
  end

  assign sck_rise = rise_s;
  assign period   = period_q;
  assign locked   = locked_q;
  assign lock_err = lock_err_q;
  assign lost     = lost_q;

endmodule
